// File: rtl/bmc_word_fifo.sv
// Timestamped first-word-fall-through FIFO behind bmc_decoder; captures {ts, word} on strobe edges.
// Optional saturating drop counter when BMC_FIFO_DROP_COUNT_EN is defined.
module bmc_word_fifo #(
  parameter int unsigned bit_considered = 17,
  parameter int unsigned ts_width       = 24,
  parameter int unsigned depth_log2     = 4
) (
  input  logic                               clk_96MHz,
  input  logic                               reset,
  input  logic                               enabled,
  input  logic [bit_considered-1:0]          decoded_data,
  input  logic                               data_availible,
  input  logic [ts_width-1:0]                ts_last_data,
  input  logic                               rd_en,
  input  logic                               clear_overflow,
  output logic [ts_width+bit_considered-1:0] rd_data,
  output logic                               rd_valid,
  output logic [depth_log2:0]                fifo_count,
  output logic                               full,
  output logic                               overflow
`ifdef BMC_FIFO_DROP_COUNT_EN
  ,
  output logic [7:0]                         drop_count
`endif
);

  localparam int unsigned Depth  = 1 << depth_log2;
  localparam int unsigned EntryW = ts_width + bit_considered;
  localparam int unsigned PtrW   = depth_log2 + 1;
  localparam logic [PtrW-1:0] DepthCnt = PtrW'(Depth);

  logic [EntryW-1:0] mem_q [Depth];

  logic            da_q, da_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;

  logic wr_req, do_wr, do_pop, drop;

  always_comb begin
    wr_req = data_availible & ~da_q & enabled;
    do_pop = rd_en & valid_q;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept the write.
    do_wr  = wr_req & (~full_q | do_pop);
    drop   = wr_req & full_q & ~do_pop;

    da_d     = data_availible;
    wr_ptr_d = do_wr  ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({do_wr, do_pop})
      2'b10:   count_d = count_q + PtrW'(1);
      2'b01:   count_d = count_q - PtrW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == DepthCnt);
    valid_d = (count_d != '0);

    ovf_d = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;
  end

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      da_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      da_q     <= da_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[depth_log2-1:0]] <= {ts_last_data, decoded_data};
    end
  end

  // Masking with valid keeps rd_data at zero out of reset despite uninitialised memory.
  assign rd_data    = valid_q ? mem_q[rd_ptr_q[depth_log2-1:0]] : '0;
  assign rd_valid   = valid_q;
  assign fifo_count = count_q;
  assign full       = full_q;
  assign overflow   = ovf_q;

`ifdef BMC_FIFO_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_overflow) drop_cnt_d = '0;
    if (drop && (drop_cnt_d != 8'hFF)) drop_cnt_d = drop_cnt_d + 8'd1;
  end

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
